// File: rtl/blinky_sequencer.sv
// LED pattern controller: prescaled step tick, debounced mode button, auto-advance timer,
// and four pattern generators (walk, bounce, binary count, PDM breathe) driving a registered bus.
module blinky_sequencer #(
  parameter int unsigned PRESCALE_W     = 4,
  parameter int unsigned STEPS_PER_MODE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       hold,
  input  logic       auto,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       tick
);

  typedef enum logic [1:0] {ModeWalk, ModeBounce, ModeCount, ModeBreathe} mode_e;

  localparam logic [7:0] LastStep = 8'(STEPS_PER_MODE - 1);

  logic [PRESCALE_W-1:0] presc_q;
  logic                  sync1_q, sync2_q;
  logic                  db_q, db_d;
  logic [1:0]            stab_q, stab_d;
  logic [7:0]            step_cnt_q, step_cnt_d;
  mode_e                 mode_q, mode_d;
  logic [2:0]            pos_q, pos_d;
  logic                  dir_q, dir_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [4:0]            level_q, level_d;
  logic                  level_dir_q, level_dir_d;
  logic [4:0]            acc_q, acc_d;
  logic [5:0]            pdm_sum;
  logic [7:0]            led_q, led_d;
  logic                  step_en, auto_step, btn_rise, adv_req;

  assign tick = (presc_q == '1) & ~reset;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_q        <= 1'b0;
      stab_q      <= '0;
      step_cnt_q  <= '0;
      mode_q      <= ModeWalk;
      pos_q       <= '0;
      dir_q       <= 1'b0;
      cnt_q       <= '0;
      level_q     <= '0;
      level_dir_q <= 1'b0;
      acc_q       <= '0;
      led_q       <= '0;
    end else begin
      presc_q     <= presc_q + PRESCALE_W'(1);
      sync1_q     <= mode_btn;
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      stab_q      <= stab_d;
      step_cnt_q  <= step_cnt_d;
      mode_q      <= mode_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dir_q <= level_dir_d;
      acc_q       <= acc_d;
      led_q       <= led_d;
    end
  end

  // Next-state logic
  always_comb begin
    db_d     = db_q;
    stab_d   = stab_q;
    btn_rise = 1'b0;
    // Stability count only survives while the synchronized input disagrees with the level.
    if (sync2_q == db_q) begin
      stab_d = '0;
    end else if (tick) begin
      if (stab_q == 2'd3) begin
        db_d     = sync2_q;
        stab_d   = '0;
        btn_rise = sync2_q;
      end else begin
        stab_d = stab_q + 2'd1;
      end
    end

    step_en   = tick & ~hold;
    auto_step = step_en & auto;
    adv_req   = btn_rise | (auto_step & (step_cnt_q == LastStep));

    step_cnt_d = step_cnt_q;
    if (adv_req || !auto) begin
      step_cnt_d = '0;
    end else if (auto_step) begin
      step_cnt_d = step_cnt_q + 8'd1;
    end

    pdm_sum     = {1'b0, acc_q} + {1'b0, level_q};
    mode_d      = mode_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    level_dir_d = level_dir_q;
    acc_d       = pdm_sum[4:0];

    if (adv_req) begin
      mode_d      = mode_e'(mode_q + 2'd1);
      pos_d       = '0;
      dir_d       = 1'b0;
      cnt_d       = '0;
      level_d     = '0;
      level_dir_d = 1'b0;
      acc_d       = '0;
    end else if (step_en) begin
      case (mode_q)
        ModeWalk:   pos_d = pos_q + 3'd1;
        ModeBounce: begin
          if (!dir_q) begin
            pos_d = pos_q + 3'd1;
            if (pos_d == 3'd7) dir_d = 1'b1;
          end else begin
            pos_d = pos_q - 3'd1;
            if (pos_d == 3'd0) dir_d = 1'b0;
          end
        end
        ModeCount:  cnt_d = cnt_q + 8'd1;
        ModeBreathe: begin
          if (!level_dir_q) begin
            level_d = level_q + 5'd1;
            if (level_d == 5'd31) level_dir_d = 1'b1;
          end else begin
            level_d = level_q - 5'd1;
            if (level_d == 5'd0) level_dir_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    case (mode_d)
      ModeWalk, ModeBounce: led_d = 8'd1 << pos_d;
      ModeCount:            led_d = cnt_d;
      default:              led_d = adv_req ? 8'h00 : {8{pdm_sum[5]}};
    endcase
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_blinky_sequencer.sv
// Self-checking bench for blinky_sequencer: scoreboarded pattern steps plus directed checks of
// reset, button debounce, auto-advance and PDM density.
module tb_blinky_sequencer;
  localparam int unsigned PW  = 2;
  localparam int unsigned SPM = 16;

  logic       clk = 1'b0;
  logic       reset, mode_btn, hold, auto_en;
  logic [7:0] led;
  logic [1:0] mode;
  logic       tick;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      tag;
    logic [7:0] led;
    logic [1:0] mode;
  } exp_t;
  exp_t sb[$];

  blinky_sequencer #(
    .PRESCALE_W    (PW),
    .STEPS_PER_MODE(SPM)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .mode_btn(mode_btn),
    .hold    (hold),
    .auto    (auto_en),
    .led     (led),
    .mode    (mode),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Returns at the negedge after the edge that ends the next tick cycle.
  task automatic next_tick(output int n);
    bit found = 1'b0;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      n++;
      if (tick) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check_eq("tick_timeout", 32'(found), 1);
    @(negedge clk);
    n++;
  endtask

  task automatic ticks(input int k);
    int n;
    for (int i = 0; i < k; i++) next_tick(n);
  endtask

  task automatic push_exp(input string tag, input logic [7:0] l, input logic [1:0] m);
    exp_t e;
    e.tag = tag; e.led = l; e.mode = m;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check_eq({e.tag, "_led"}, 32'(led), 32'(e.led));
      check_eq({e.tag, "_mode"}, 32'(mode), 32'(e.mode));
    end
  endtask

  task automatic step_check(input string tag, input logic [7:0] l, input logic [1:0] m);
    int n;
    push_exp(tag, l, m);
    next_tick(n);
    pop_cmp();
  endtask

  // Press from a tick-aligned point; debounced edge lands on the 4th tick.
  task automatic press_to(input logic [1:0] want);
    int n, tot;
    tot = 0;
    mode_btn = 1'b1;
    while (mode != want && tot < 12) begin
      next_tick(n);
      tot++;
    end
    check_eq("btn_latency", 32'(tot), 4);
    check_eq("press_mode", 32'(mode), 32'(want));
    check_eq("press_led", 32'(led), (want < 2) ? 32'h01 : 32'h00);
    mode_btn = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         n, ff_cnt, other_cnt, m, p;
    logic [1:0] exp_mode;
    logic [7:0] held;

    reset = 1'b1; mode_btn = 1'b0; hold = 1'b0; auto_en = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_led", 32'(led), 0);
      check_eq("rst_mode", 32'(mode), 0);
      check_eq("rst_tick", 32'(tick), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_led", 32'(led), 32'h01);

    // Walk with tick period
    for (int k = 1; k <= 8; k++) begin
      push_exp("walk", 8'd1 << (k % 8), 2'd0);
      next_tick(n);
      pop_cmp();
      if (k > 1) check_eq("tick_period", 32'(n), 4);
    end

    // Bounce
    press_to(2'd1);
    for (int k = 1; k <= 16; k++) begin
      m = k % 14;
      p = (m <= 7) ? m : 14 - m;
      step_check("bounce", 8'd1 << p, 2'd1);
    end

    // Count wrap then hold
    press_to(2'd2);
    for (int k = 1; k <= 256; k++) step_check("count", 8'(k % 256), 2'd2);
    hold = 1'b1;
    for (int k = 0; k < 10; k++) step_check("count_hold", 8'h00, 2'd2);
    hold = 1'b0;

    // Breathe density at level 16
    press_to(2'd3);
    ticks(16);
    hold = 1'b1;
    ff_cnt = 0; other_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (led == 8'hFF) ff_cnt++;
      else if (led != 8'h00) other_cnt++;
    end
    check_eq("breathe_ff_count", 32'(ff_cnt), 16);
    check_eq("breathe_other", 32'(other_cnt), 0);
    hold = 1'b0;
    ticks(3);

    // Reset mid-pattern
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_led", 32'(led), 0);
    check_eq("midrst_mode", 32'(mode), 0);
    check_eq("midrst_tick", 32'(tick), 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_post_led", 32'(led), 32'h01);
    ticks(1);

    // Debounce: short pulse, medium press, long press
    mode_btn = 1'b1; ticks(2); mode_btn = 1'b0; ticks(8);
    check_eq("deb_short", 32'(mode), 0);
    mode_btn = 1'b1; ticks(6); mode_btn = 1'b0; ticks(6);
    check_eq("deb_6", 32'(mode), 1);
    mode_btn = 1'b1; ticks(100); mode_btn = 1'b0; ticks(6);
    check_eq("deb_100", 32'(mode), 2);

    // Auto-advance from a fresh reset
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ticks(1);
    auto_en  = 1'b1;
    exp_mode = 2'd0;
    for (int e = 0; e < 4; e++) begin
      int tot;
      tot = 0;
      held = {6'd0, mode};
      while (mode == held[1:0] && tot < 40) begin
        next_tick(n);
        tot++;
      end
      exp_mode = exp_mode + 2'd1;
      check_eq("auto_ticks", 32'(tot), SPM);
      check_eq("auto_mode", 32'(mode), 32'(exp_mode));
      check_eq("auto_led", 32'(led), (exp_mode < 2) ? 32'h01 : 32'h00);
    end

    // Button edge coinciding with auto expiry
    ticks(12);
    mode_btn = 1'b1;
    ticks(4);
    check_eq("coinc_mode", 32'(mode), 1);
    mode_btn = 1'b0;
    ticks(8);
    check_eq("coinc_after", 32'(mode), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
